// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: sequential binary-to-BCD conversion feeding
// a time-multiplexed digit scanner with blanking, sign, overflow and dp handling.
`timescale 1ns/1ps

module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned SIGNED       = 0,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [NUM_DIGITS-1:0] dp_in,
    output logic                  busy,
    output logic [6:0]            out_cathode,
    output logic                  out_dp,
    output logic [NUM_DIGITS-1:0] anode
);

    localparam int unsigned BCD_DIGITS = (DATA_WIDTH + 2) / 3;
    localparam int unsigned BCD_W      = BCD_DIGITS * 4;
    localparam int unsigned CNT_W      = $clog2(DATA_WIDTH + 1);
    localparam int unsigned MSD_W      = $clog2(BCD_DIGITS);
    localparam int unsigned PRE_W      = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Converter state
    state_t                r_state;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_bin;
    logic [BCD_W-1:0]      r_bcd;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_neg;
    logic [NUM_DIGITS-1:0] r_dp_lat;

    // Display register (updated atomically at the end of a conversion)
    logic [BCD_W-1:0]      r_disp_bcd;
    logic [MSD_W-1:0]      r_disp_msd;
    logic                  r_disp_neg;
    logic                  r_disp_ovf;
    logic [NUM_DIGITS-1:0] r_disp_dp;

    // Scanner state and registered pins
    logic [PRE_W-1:0]      r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_DIGITS-1:0] r_anode;
    logic [6:0]            r_cathode;
    logic                  r_dp_n;

    logic                  w_in_neg;
    logic [DATA_WIDTH-1:0] w_mag;
    logic [MSD_W-1:0]      w_msd;
    logic                  w_neg_eff;
    logic                  w_ovf;
    logic                  w_wrap;
    logic [PRE_W-1:0]      w_presc_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [3:0]            w_nib;
    logic [6:0]            w_seg;
    logic                  w_dp_n;
    logic [NUM_DIGITS-1:0] w_anode;

    // Decimal digit to active-low segment pattern {a,b,c,d,e,f,g}
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // One double-dabble iteration: add 3 to every digit >= 5, then shift in a bit
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd,
                                                 input logic             bit_in);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

    // Input magnitude and sign; the most negative value maps to 2^(DATA_WIDTH-1)
    always_comb begin
        w_in_neg = (SIGNED != 0) && data_in[DATA_WIDTH-1];
        w_mag    = data_in;
        if (w_in_neg) begin
            w_mag = (~data_in) + DATA_WIDTH'(1);
        end
    end

    // Most significant nonzero digit, effective sign and overflow of the result
    always_comb begin
        w_msd = '0;
        for (int i = 1; i < int'(BCD_DIGITS); i++) begin
            if (r_bcd[i*4 +: 4] != 4'd0) begin
                w_msd = MSD_W'(i);
            end
        end
        w_neg_eff = r_neg && (r_bcd != '0);
        w_ovf     = (int'(w_msd) + 1) > (int'(NUM_DIGITS) - (w_neg_eff ? 1 : 0));
    end

    // Converter FSM: IDLE -> CONV (DATA_WIDTH iterations) -> DONE (commit) -> IDLE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_dp_lat   <= '0;
            r_disp_bcd <= '0;
            r_disp_msd <= '0;
            r_disp_neg <= 1'b0;
            r_disp_ovf <= 1'b0;
            r_disp_dp  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_bin    <= w_mag;
                        r_neg    <= w_in_neg;
                        r_dp_lat <= dp_in;
                        r_bcd    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_bcd <= dd_step(r_bcd, r_bin[DATA_WIDTH-1]);
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_disp_bcd <= r_bcd;
                    r_disp_msd <= w_msd;
                    r_disp_neg <= w_neg_eff;
                    r_disp_ovf <= w_ovf;
                    r_disp_dp  <= r_dp_lat;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Next prescaler / scan index; outputs are derived from these so pins align with the slot
    always_comb begin
        w_wrap      = (r_presc == PRE_W'(REFRESH_DIV - 1));
        w_presc_nxt = r_presc + PRE_W'(1);
        w_idx_nxt   = r_idx;
        if (w_wrap) begin
            w_presc_nxt = '0;
            if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
                w_idx_nxt = '0;
            end else begin
                w_idx_nxt = r_idx + IDX_W'(1);
            end
        end
    end

    // Segment, dp and anode pattern for the digit being scanned next
    always_comb begin
        w_nib = 4'd0;
        for (int b = 0; b < int'(BCD_DIGITS); b++) begin
            if (int'(w_idx_nxt) == b) begin
                w_nib = r_disp_bcd[b*4 +: 4];
            end
        end

        w_dp_n = 1'b1;
        for (int a = 0; a < int'(NUM_DIGITS); a++) begin
            if (int'(w_idx_nxt) == a) begin
                w_dp_n = ~r_disp_dp[a];
            end
        end

        w_seg = seg_code(w_nib);
        if (r_disp_ovf) begin
            w_seg  = SEG_DASH;
            w_dp_n = 1'b1;
        end else if (r_disp_neg && (int'(w_idx_nxt) == int'(NUM_DIGITS) - 1)) begin
            w_seg = SEG_DASH;
        end else if (int'(w_idx_nxt) > int'(r_disp_msd)) begin
            w_seg = SEG_BLANK;
        end

        w_anode = '1;
        for (int a = 0; a < int'(NUM_DIGITS); a++) begin
            if ((w_presc_nxt >= PRE_W'(BLANK_CYCLES)) && (int'(w_idx_nxt) == a)) begin
                w_anode[a] = 1'b0;
            end
        end
    end

    // Scanner: free-running prescaler and digit index with registered pin drive
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_presc   <= '0;
            r_idx     <= '0;
            r_anode   <= '1;
            r_cathode <= SEG_BLANK;
            r_dp_n    <= 1'b1;
        end else begin
            r_presc   <= w_presc_nxt;
            r_idx     <= w_idx_nxt;
            r_anode   <= w_anode;
            r_cathode <= w_seg;
            r_dp_n    <= w_dp_n;
        end
    end

    assign busy        = r_busy;
    assign out_cathode = r_cathode;
    assign out_dp      = r_dp_n;
    assign anode       = r_anode;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: three instances (unsigned 4-digit,
// signed 4-digit, unsigned 2-digit) share stimulus; each has its own reference image.
`timescale 1ns/1ps

module tb_seg7_scan_driver;

    localparam int DW  = 8;
    localparam int RD  = 8;
    localparam int BLK = 2;

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [3:0]      dpn;
    } img_t;

    // Index 0: unsigned/4 digits, 1: signed/4 digits, 2: unsigned/2 digits
    typedef img_t [2:0] trio_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic [3:0] dp_in = 4'd0;

    logic       busy0, busy1, busy2;
    logic [6:0] cath0, cath1, cath2;
    logic       dp0, dp1, dp2;
    logic [3:0] an0, an1;
    logic [1:0] an2;

    int    n_chk = 0;
    int    n_fail = 0;
    int    n = 0;
    int    last_e = -1000;
    int    next_ok = 0;
    trio_t exp_q[$];
    trio_t cur, pend, rimg;
    bit    pend_v = 0;
    bit    prev_busy = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(4), .DATA_WIDTH(DW), .SIGNED(0), .REFRESH_DIV(RD), .BLANK_CYCLES(BLK)) u_dut0 (
        .clock(clk), .reset(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
        .busy(busy0), .out_cathode(cath0), .out_dp(dp0), .anode(an0));

    seg7_scan_driver #(.NUM_DIGITS(4), .DATA_WIDTH(DW), .SIGNED(1), .REFRESH_DIV(RD), .BLANK_CYCLES(BLK)) u_dut1 (
        .clock(clk), .reset(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
        .busy(busy1), .out_cathode(cath1), .out_dp(dp1), .anode(an1));

    seg7_scan_driver #(.NUM_DIGITS(2), .DATA_WIDTH(DW), .SIGNED(0), .REFRESH_DIV(RD), .BLANK_CYCLES(BLK)) u_dut2 (
        .clock(clk), .reset(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in[1:0]),
        .busy(busy2), .out_cathode(cath2), .out_dp(dp2), .anode(an2));

    // Rising edges seen since reset release (prescaler/scan reference)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    // Reference: decimal rendering of a value with plain integer arithmetic
    function automatic img_t model(input int v, input int sg, input int nd, input logic [3:0] dp);
        img_t r;
        int val, mag, ndig, p, t;
        bit neg, ovf;
        val  = (sg != 0 && v >= 128) ? v - 256 : v;
        neg  = val < 0;
        mag  = neg ? -val : val;
        ndig = 1;
        p    = 10;
        while (mag >= p) begin
            ndig++;
            p = p * 10;
        end
        ovf = ndig > (nd - (neg ? 1 : 0));
        for (int i = 0; i < 4; i++) begin
            r.seg[i] = 7'b1111111;
            r.dpn[i] = 1'b1;
            if (i < nd) begin
                if (ovf) begin
                    r.seg[i] = 7'b1111110;
                end else begin
                    r.dpn[i] = ~dp[i];
                    if (neg && i == nd - 1) begin
                        r.seg[i] = 7'b1111110;
                    end else if (i < ndig) begin
                        t = mag;
                        for (int j = 0; j < i; j++) t = t / 10;
                        r.seg[i] = seg_of(t % 10);
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic check_dut(input int d, input int nd, input logic bsy, input bit bexp,
                             input logic [3:0] an, input logic [6:0] ca, input logic dp,
                             input img_t im);
        int presc, idx;
        logic [3:0] an_exp;
        chk($sformatf("d%0d busy n=%0d", d, n), 32'(bsy), 32'(bexp));
        if (n == 0) begin
            chk($sformatf("d%0d anode n=0", d), 32'(an), 32'hF);
            chk($sformatf("d%0d cathode n=0", d), 32'(ca), 32'h7F);
            chk($sformatf("d%0d dp n=0", d), 32'(dp), 32'h1);
        end else begin
            presc  = n % RD;
            idx    = (n / RD) % nd;
            an_exp = 4'hF;
            if (presc >= BLK) an_exp[idx] = 1'b0;
            chk($sformatf("d%0d anode n=%0d", d, n), 32'(an), 32'(an_exp));
            chk($sformatf("d%0d cathode n=%0d dig%0d", d, n, idx), 32'(ca), 32'(im.seg[idx]));
            chk($sformatf("d%0d dp n=%0d dig%0d", d, n, idx), 32'(dp), 32'(im.dpn[idx]));
        end
    endtask

    // Monitor: compares every cycle; adopts the next expected image when busy falls
    always @(negedge clk) begin
        bit bexp;
        if (!rst_n) begin
            cur    = rimg;
            pend_v = 0;
            exp_q.delete();
            prev_busy = 0;
            chk("rst busy0", 32'(busy0), 0);
            chk("rst busy1", 32'(busy1), 0);
            chk("rst anode0", 32'(an0), 32'hF);
            chk("rst anode2", 32'(an2), 32'h3);
            chk("rst cathode1", 32'(cath1), 32'h7F);
            chk("rst dp2", 32'(dp2), 1);
        end else begin
            if (pend_v) begin
                cur    = pend;
                pend_v = 0;
            end
            bexp = (last_e >= 0) && (n >= last_e) && (n <= last_e + DW);
            check_dut(0, 4, busy0, bexp, an0, cath0, dp0, cur[0]);
            check_dut(1, 4, busy1, bexp, an1, cath1, dp1, cur[1]);
            check_dut(2, 2, busy2, bexp, {2'b11, an2}, cath2, dp2, cur[2]);
            if (prev_busy && !busy0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected completion", 1, 0);
                end else begin
                    pend   = exp_q.pop_front();
                    pend_v = 1;
                end
            end
            prev_busy = busy0;
        end
    end

    task automatic do_load(input int v, input logic [3:0] dp);
        int e;
        trio_t t;
        @(negedge clk); #1;
        data_in = 8'(v);
        dp_in   = dp;
        load    = 1'b1;
        e = n + 1;
        if (e >= next_ok) begin
            t[0] = model(v, 0, 4, dp);
            t[1] = model(v, 1, 4, dp);
            t[2] = model(v, 0, 2, dp);
            exp_q.push_back(t);
            last_e  = e;
            next_ok = e + DW + 2;
        end
        @(negedge clk); #1;
        load    = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic wait_cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_reset(input int k);
        @(negedge clk); #1;
        rst_n   = 1'b0;
        last_e  = -1000;
        next_ok = 0;
        wait_cycles(k);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rimg[0] = model(0, 0, 4, 4'd0);
        rimg[1] = model(0, 1, 4, 4'd0);
        rimg[2] = model(0, 0, 2, 4'd0);
        cur     = rimg;

        wait_cycles(3);
        #1 rst_n = 1'b1;
        wait_cycles(40);

        do_load(25, 4'b0000);     wait_cycles(45);
        do_load(8'hE9, 4'b0000);  wait_cycles(45);
        do_load(200, 4'b0000);    wait_cycles(45);
        do_load(99, 4'b0000);     wait_cycles(45);
        do_load(7, 4'b0000);
        do_load(3, 4'b0000);      wait_cycles(45);
        do_load(42, 4'b0010);     wait_cycles(45);
        do_load(128, 4'b1111);    wait_cycles(45);
        do_load(0, 4'b0101);      wait_cycles(45);
        do_load(255, 4'b1000);    wait_cycles(45);
        do_load(123, 4'b0000);
        wait_cycles(3);
        pulse_reset(2);
        wait_cycles(45);

        for (int i = 0; i < 40; i++) begin
            do_load(int'($urandom_range(0, 255)), 4'($urandom));
            wait_cycles(int'($urandom_range(0, 40)));
        end

        wait_cycles(50);
        chk("queue drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
